// File: rtl/serial_invert_deserializer.sv
// Serial-to-parallel packer with per-bit optional inversion. Bits are packed LSB-first into
// WIDTH-bit words. One completed word can be parked while the output register is stalled.
module serial_invert_deserializer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic             up_data,
   input  logic             up_last,
   input  logic             invert,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [WIDTH-1:0] down_data,
   output logic [CNT_W-1:0] down_count,
   output logic             down_last
);

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] HOLD    = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] bit_idx;
   logic [WIDTH-1:0] pend_data;
   logic [CNT_W-1:0] pend_count;
   logic             pend_last;

   logic             accept;
   logic             complete;
   logic             slot_free;
   logic [WIDTH-1:0] word;
   logic [CNT_W-1:0] word_count;

   // Positions above idx keep their cleared value, so a flushed partial word is zero-padded.
   function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] base,
                                                    input logic [CNT_W-1:0] idx,
                                                    input logic             b);
      logic [WIDTH-1:0] r;
      r = base;
      for (int i = 0; i < WIDTH; i++) begin
         if (idx == CNT_W'(i)) r[i] = b;
      end
      return r;
   endfunction

   assign up_ready   = (state == COLLECT);
   assign accept     = up_valid && up_ready;
   assign complete   = accept && (up_last || (bit_idx == CNT_W'(WIDTH - 1)));
   assign slot_free  = !down_valid || down_ready;
   assign word       = insert_bit(shift_reg, bit_idx, up_data ^ invert);
   assign word_count = bit_idx + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= COLLECT;
         shift_reg  <= '0;
         bit_idx    <= '0;
         pend_data  <= '0;
         pend_count <= '0;
         pend_last  <= 1'b0;
         down_valid <= 1'b0;
         down_data  <= '0;
         down_count <= '0;
         down_last  <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (down_valid && down_ready) down_valid <= 1'b0;
               if (accept) begin
                  if (complete) begin
                     shift_reg <= '0;
                     bit_idx   <= '0;
                     // A draining output slot counts as free, so the new word overrides the clear above.
                     if (slot_free) begin
                        down_data  <= word;
                        down_count <= word_count;
                        down_last  <= up_last;
                        down_valid <= 1'b1;
                     end else begin
                        pend_data  <= word;
                        pend_count <= word_count;
                        pend_last  <= up_last;
                        state      <= HOLD;
                     end
                  end else begin
                     shift_reg <= word;
                     bit_idx   <= word_count;
                  end
               end
            end
            default: begin
               if (down_ready) begin
                  down_data  <= pend_data;
                  down_count <= pend_count;
                  down_last  <= pend_last;
                  down_valid <= 1'b1;
                  state      <= COLLECT;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_invert_deserializer.sv
// Self-checking bench: directed scenarios from the plan plus a randomized run against a
// word-level queue model of the packer.
module tb_serial_invert_deserializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       up_valid, up_data, up_last, invert, down_ready;
   logic       up_ready, down_valid, down_last;
   logic [7:0] down_data;
   logic [3:0] down_count;

   int checks = 0;
   int errors = 0;

   serial_invert_deserializer #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
      .up_last(up_last), .invert(invert),
      .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
      .down_count(down_count), .down_last(down_last)
   );

   always #5 clk = ~clk;

   // Presents one bit and returns at 1 time unit after the edge that accepted it.
   task automatic send_bit(input logic d, input logic inv, input logic last);
      up_valid = 1'b1; up_data = d; invert = inv; up_last = last;
      for (int t = 0; t < 50 && !up_ready; t++) begin
         @(posedge clk); #1;
      end
      if (!up_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: up_ready=%b required 1 within 50 cycles", up_ready);
      end
      @(posedge clk); #1;
      up_valid = 1'b0; up_last = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] bits, input int n, input logic inv, input logic last_end);
      for (int i = 0; i < n; i++) send_bit(bits[i], inv, last_end && (i == n - 1));
   endtask

   task automatic test_reset;
      rst = 1'b1; up_valid = 1'b0; up_data = 1'b0; up_last = 1'b0; invert = 1'b0; down_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (down_valid !== 1'b0 || down_data !== 8'h00 || down_count !== 4'd0 || down_last !== 1'b0 || up_ready !== 1'b1)
         begin errors++; $display("FAIL reset_values: v=%b d=%h c=%0d l=%b r=%b required 0/00/0/0/1",
                                  down_valid, down_data, down_count, down_last, up_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_plain_word;
      down_ready = 1'b1;
      send_word(8'h8D, 8, 1'b0, 1'b0);
      checks++;
      if (down_valid !== 1'b1 || down_data !== 8'h8D || down_count !== 4'd8 || down_last !== 1'b0)
         begin errors++; $display("FAIL plain_word: v=%b d=%h c=%0d l=%b required 1/8d/8/0",
                                  down_valid, down_data, down_count, down_last); end
      @(posedge clk); #1;
      checks++;
      if (down_valid !== 1'b0 || down_data !== 8'h8D)
         begin errors++; $display("FAIL plain_drain: v=%b d=%h required 0/8d", down_valid, down_data); end
   endtask

   task automatic test_inverted_word;
      down_ready = 1'b1;
      send_word(8'h8D, 8, 1'b1, 1'b0);
      checks++;
      if (down_valid !== 1'b1 || down_data !== 8'h72 || down_count !== 4'd8 || down_last !== 1'b0)
         begin errors++; $display("FAIL inverted_word: v=%b d=%h c=%0d l=%b required 1/72/8/0",
                                  down_valid, down_data, down_count, down_last); end
      @(posedge clk); #1;
   endtask

   task automatic test_partial_last;
      down_ready = 1'b1;
      send_word(8'h07, 3, 1'b1, 1'b1);
      checks++;
      if (down_valid !== 1'b1 || down_data !== 8'h00 || down_count !== 4'd3 || down_last !== 1'b1)
         begin errors++; $display("FAIL partial3_inv: v=%b d=%h c=%0d l=%b required 1/00/3/1",
                                  down_valid, down_data, down_count, down_last); end
      send_word(8'h03, 2, 1'b0, 1'b1);
      checks++;
      if (down_valid !== 1'b1 || down_data !== 8'h03 || down_count !== 4'd2 || down_last !== 1'b1)
         begin errors++; $display("FAIL partial2: v=%b d=%h c=%0d l=%b required 1/03/2/1",
                                  down_valid, down_data, down_count, down_last); end
      send_bit(1'b0, 1'b1, 1'b1);
      checks++;
      if (down_valid !== 1'b1 || down_data !== 8'h01 || down_count !== 4'd1 || down_last !== 1'b1)
         begin errors++; $display("FAIL first_bit_last: v=%b d=%h c=%0d l=%b required 1/01/1/1",
                                  down_valid, down_data, down_count, down_last); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_pressure;
      down_ready = 1'b0;
      send_word(8'hFF, 8, 1'b0, 1'b0);
      send_word(8'hFF, 8, 1'b0, 1'b0);
      checks++;
      if (up_ready !== 1'b0 || down_valid !== 1'b1 || down_data !== 8'hFF || down_count !== 4'd8)
         begin errors++; $display("FAIL hold_entry: r=%b v=%b d=%h c=%0d required 0/1/ff/8",
                                  up_ready, down_valid, down_data, down_count); end
      @(posedge clk); #1;
      checks++;
      if (up_ready !== 1'b0 || down_valid !== 1'b1 || down_data !== 8'hFF)
         begin errors++; $display("FAIL hold_stable: r=%b v=%b d=%h required 0/1/ff", up_ready, down_valid, down_data); end
      down_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (up_ready !== 1'b1 || down_valid !== 1'b1 || down_data !== 8'hFF || down_count !== 4'd8 || down_last !== 1'b0)
         begin errors++; $display("FAIL hold_release: r=%b v=%b d=%h c=%0d l=%b required 1/1/ff/8/0",
                                  up_ready, down_valid, down_data, down_count, down_last); end
      @(posedge clk); #1;
      checks++;
      if (down_valid !== 1'b0)
         begin errors++; $display("FAIL hold_drain: v=%b required 0", down_valid); end
   endtask

   task automatic test_async_reset;
      down_ready = 1'b0;
      send_word(8'hA5, 8, 1'b0, 1'b0);
      send_word(8'h1F, 5, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (down_valid !== 1'b0 || down_data !== 8'h00 || down_count !== 4'd0 || down_last !== 1'b0 || up_ready !== 1'b1)
         begin errors++; $display("FAIL async_mid_word: v=%b d=%h c=%0d l=%b r=%b required 0/00/0/0/1",
                                  down_valid, down_data, down_count, down_last, up_ready); end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      down_ready = 1'b1;
      send_word(8'h5A, 8, 1'b0, 1'b0);
      checks++;
      if (down_valid !== 1'b1 || down_data !== 8'h5A || down_count !== 4'd8)
         begin errors++; $display("FAIL after_mid_reset: v=%b d=%h c=%0d required 1/5a/8",
                                  down_valid, down_data, down_count); end
      @(posedge clk); #1;
      down_ready = 1'b0;
      send_word(8'hFF, 8, 1'b0, 1'b0);
      send_word(8'h00, 8, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (up_ready !== 1'b1 || down_valid !== 1'b0 || down_data !== 8'h00 || down_count !== 4'd0)
         begin errors++; $display("FAIL async_in_hold: r=%b v=%b d=%h c=%0d required 1/0/00/0",
                                  up_ready, down_valid, down_data, down_count); end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      down_ready = 1'b1;
      send_word(8'hC3, 8, 1'b0, 1'b1);
      checks++;
      if (down_valid !== 1'b1 || down_data !== 8'hC3 || down_count !== 4'd8 || down_last !== 1'b1)
         begin errors++; $display("FAIL after_hold_reset: v=%b d=%h c=%0d l=%b required 1/c3/8/1",
                                  down_valid, down_data, down_count, down_last); end
      @(posedge clk); #1;
   endtask

   // Model: bits accepted so far form words of 8 or end at up_last; words not yet taken
   // downstream sit in a queue. One word fits in the output, one more in the parking slot.
   task automatic test_random;
      logic [7:0] qd[$];
      int         qc[$];
      logic       ql[$];
      logic       cur[$];
      logic [7:0] w, sd;
      logic [3:0] sc;
      logic       sl, stall, bitv;
      int         sent, cyc, nout;
      sent = 0; cyc = 0; stall = 1'b0; sd = '0; sc = '0; sl = 1'b0;
      rst = 1'b1; #2 rst = 1'b0;
      @(posedge clk); #1;
      while ((sent < 1000 || qd.size() > 0) && cyc < 20000) begin
         nout = qd.size();
         checks++;
         if (down_valid !== (nout > 0) || up_ready !== (nout < 2))
            begin errors++; $display("FAIL rand_flags cyc %0d: v=%b r=%b required %b/%b",
                                     cyc, down_valid, up_ready, nout > 0, nout < 2); end
         if (stall) begin
            checks++;
            if (down_valid !== 1'b1 || down_data !== sd || down_count !== sc || down_last !== sl)
               begin errors++; $display("FAIL rand_stall cyc %0d: v=%b d=%h c=%0d l=%b required 1/%h/%0d/%b",
                                        cyc, down_valid, down_data, down_count, down_last, sd, sc, sl); end
         end
         up_valid   = (sent < 1000) && ($urandom_range(9) >= 3);
         up_data    = 1'($urandom_range(1));
         invert     = 1'($urandom_range(1));
         up_last    = (sent == 999) || ($urandom_range(9) == 0);
         down_ready = ($urandom_range(9) >= 3);
         if (down_ready && nout > 0) begin
            checks++;
            if (down_data !== qd[0] || down_count !== 4'(qc[0]) || down_last !== ql[0])
               begin errors++; $display("FAIL rand_word cyc %0d: d=%h c=%0d l=%b required %h/%0d/%b",
                                        cyc, down_data, down_count, down_last, qd[0], qc[0], ql[0]); end
            void'(qd.pop_front()); void'(qc.pop_front()); void'(ql.pop_front());
         end
         if (up_valid && nout < 2) begin
            bitv = up_data ^ invert;
            cur.push_back(bitv);
            sent++;
            if (up_last || cur.size() == 8) begin
               w = '0;
               foreach (cur[i]) w[i] = cur[i];
               qd.push_back(w); qc.push_back(cur.size()); ql.push_back(up_last);
               cur.delete();
            end
         end
         stall = down_valid && !down_ready;
         sd = down_data; sc = down_count; sl = down_last;
         @(posedge clk); #1;
         cyc++;
      end
      up_valid = 1'b0; up_last = 1'b0;
      checks++;
      if (cyc >= 20000 || cur.size() != 0 || sent != 1000)
         begin errors++; $display("FAIL rand_complete: cycles=%0d leftover=%0d sent=%0d required <20000/0/1000",
                                  cyc, cur.size(), sent); end
   endtask

   initial begin
      test_reset();
      test_plain_word();
      test_inverted_word();
      test_partial_last();
      test_back_pressure();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_invert_deserializer.md
Name: serial_invert_deserializer

Overview:
- Downstream stage for the single-bit mux-based inverter path: accepts a serial bit stream, optionally inverts each bit and packs bits LSB-first into WIDTH-bit words.
- Upstream side uses a valid/ready handshake; downstream side uses a valid/ready handshake with a registered output.
- Holds one completed word while the output register is still occupied, so collection continues while downstream stalls.

Parameters:
- WIDTH, 8, number of bits per output word; legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH+1), width of the bit-count field; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- up_valid  input  1  upstream bit valid.
- up_ready  output  1  stage can accept a bit this cycle.
- up_data  input  1  serial data bit.
- up_last  input  1  the accepted bit is the final bit of a packet; flushes a partial word.
- invert  input  1  when 1, the accepted bit is stored as up_data inverted (up_data ^ invert); sampled per accepted bit.
- down_valid  output  1  output word valid.
- down_ready  input  1  downstream accepts the word.
- down_data  output  WIDTH  packed word; bit 0 is the first accepted bit.
- down_count  output  CNT_W  number of valid bits in down_data, 1..WIDTH.
- down_last  output  1  word was terminated by up_last.

Behaviour:
- Handshakes:
  - Upstream accept = up_valid && up_ready.
  - Downstream transfer = down_valid && down_ready.
  - up_ready is a pure function of state; it has no combinational path from any input.
- States:
  - COLLECT: up_ready=1.
  - HOLD: up_ready=0; a completed word is parked in the pending register.
- Collecting bits:
  - On each upstream accept in COLLECT: store bit (up_data ^ invert) at shift position bit_idx, then increment bit_idx.
  - A word completes when bit_idx==WIDTH-1 or up_last=1.
  - Unfilled upper bits of a completed word are 0. Padding is never inverted.
- Completion routing, evaluated on the same edge as the completing accept:
  - If the output slot is free (!down_valid) or is draining this cycle (down_valid && down_ready): load the word directly into down_data/down_count/down_last, set down_valid=1, stay in COLLECT.
  - Otherwise: copy the word into the pending register and go to HOLD.
  - In both cases bit_idx returns to 0 and the shift register clears.
- Latency: down_valid rises on the edge that accepts the completing bit, i.e. it is visible in the cycle after that handshake.
- HOLD:
  - On a downstream transfer: load the pending word into the output register, keep down_valid=1, go to COLLECT.
  - Otherwise hold everything stable.
- Output register:
  - If a downstream transfer occurs with no new word to load, down_valid goes to 0 and down_data/down_count/down_last keep their old values.
  - While down_valid=1 && !down_ready, all down_* outputs are stable.
- Boundary cases:
  - up_last on the WIDTH-th bit: down_count=WIDTH, down_last=1.
  - up_last on the first bit: down_count=1.
  - The invert value can change between bits; each bit uses the invert value sampled with that bit.
- Reset (asynchronous, any time, including mid-word or in HOLD):
  - State=COLLECT, up_ready=1, bit_idx=0, shift/pending registers=0.
  - down_valid=0, down_data=0, down_count=0, down_last=0.
  - Any partially collected word is discarded.
- Sustained throughput: one bit per cycle in COLLECT. Downstream stalls only back-pressure upstream once a second word completes while the output register is full.

Test Plan:
- Reset then 8 accepted bits 1,0,1,1,0,0,0,1 with invert=0, down_ready=1 -> down_valid=1 the cycle after the 8th bit, down_data=8'h8D, down_count=8, down_last=0, then down_valid drops.
- Same 8 bits with invert=1 -> down_data=8'h72, down_count=8.
- Bits 1,1,1 with up_last on the 3rd bit, invert=1 -> down_data=8'h00, down_count=3, down_last=1; then bits 1,1 with up_last on the 2nd, invert=0 -> down_data=8'h03, down_count=2, down_last=1.
- down_ready=0, stream 16 bits of 1 -> first word 8'hFF held stable on down_*; up_ready=0 after the 16th accept (HOLD); raise down_ready -> first word transfers, 8'hFF loaded next, up_ready=1 the following cycle; no bits lost.
- Assert rst asynchronously after 5 bits and again while in HOLD -> all outputs reach their reset values immediately; the next full 8-bit word after release packs from bit 0 with no residue.
- Random up_valid/down_ready with ~30% idle/stall for 1000 bits versus a scoreboard -> every word matches, down_count/down_last are correct, and down_* never changes while stalled.
